// File: rtl/chip8_call_ret_unit.sv
// CALL/RET sequencer between Chip-8 decode and the 16-entry return stack.
// Build option CHIP8_STACK_GUARD_EN: overflow/underflow trap to ERR and set fault.
//
// state  | meaning
// S_IDLE | waiting for start; captures opcode/pc and decodes
// S_PUSH | push return address, load CALL target, done
// S_POP  | pop command to the stack
// S_LOAD | load popped address as new pc, done
// S_NOP  | non-subroutine opcode, done only
// S_ERR  | overflow/underflow trap, done only (guard build)
module chip8_call_ret_unit #(
  parameter int DEPTH = 16
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] opcode,
  input  logic [15:0] pc,
  output logic [1:0]  stk_we,
  output logic [15:0] stk_wdata,
  input  logic [15:0] stk_rdata,
  output logic        busy,
  output logic        done,
  output logic        pc_load,
  output logic [15:0] new_pc,
  output logic        fault,
  output logic [4:0]  depth
);

`ifdef CHIP8_STACK_GUARD_EN
  typedef enum logic [2:0] {S_IDLE, S_PUSH, S_POP, S_LOAD, S_NOP, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_PUSH, S_POP, S_LOAD, S_NOP} state_t;
`endif

  if (DEPTH < 1 || DEPTH > 31) begin : g_bad_depth
    $error("chip8_call_ret_unit: DEPTH must fit the 5-bit depth counter");
  end

  state_t      state_q, state_d;
  logic [11:0] target_q;
  logic [15:0] pc_q;
  logic [4:0]  depth_q;
  logic        is_call, is_ret;

  assign is_call = (opcode[15:12] == 4'h2);
  assign is_ret  = (opcode == 16'h00EE);

`ifdef CHIP8_STACK_GUARD_EN
  localparam logic [4:0] DEPTH_MAX = 5'(DEPTH);
  logic fault_q;
  logic stack_full, stack_empty;
  assign stack_full  = (depth_q == DEPTH_MAX);
  assign stack_empty = (depth_q == 5'd0);
  assign fault       = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    stk_we    = 2'b00;
    stk_wdata = 16'h0000;
    new_pc    = 16'h0000;
    pc_load   = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef CHIP8_STACK_GUARD_EN
          if (is_call)     state_d = stack_full  ? S_ERR : S_PUSH;
          else if (is_ret) state_d = stack_empty ? S_ERR : S_POP;
          else             state_d = S_NOP;
`else
          if (is_call)     state_d = S_PUSH;
          else if (is_ret) state_d = S_POP;
          else             state_d = S_NOP;
`endif
        end
      end
      S_PUSH: begin
        stk_we    = 2'b01;
        stk_wdata = pc_q + 16'd2;
        new_pc    = {4'h0, target_q};
        pc_load   = 1'b1;
        done      = 1'b1;
        state_d   = S_IDLE;
      end
      S_POP: begin
        stk_we  = 2'b10;
        state_d = S_LOAD;
      end
      // Stack output is registered, so the popped address appears here.
      S_LOAD: begin
        new_pc  = stk_rdata;
        pc_load = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign depth = depth_q;

  // Depth moves on the accepting edge so it is current during the command cycle.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      target_q <= 12'h000;
      pc_q     <= 16'h0000;
      depth_q  <= 5'd0;
`ifdef CHIP8_STACK_GUARD_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        target_q <= opcode[11:0];
        pc_q     <= pc;
      end
      if (state_q == S_IDLE && state_d == S_PUSH) depth_q <= depth_q + 5'd1;
      if (state_q == S_IDLE && state_d == S_POP)  depth_q <= depth_q - 5'd1;
`ifdef CHIP8_STACK_GUARD_EN
      if (state_d == S_ERR) fault_q <= 1'b1;
`endif
    end
  end

endmodule

// File: doc/chip8_call_ret_unit.md
# chip8_call_ret_unit

Subroutine sequencer between the Chip-8 CPU decode stage and `Chip8_Stack`. Executes CALL (`2NNN`) and RET (`00EE`) on request: it drives the stack's push/pop command and return-address data, and hands the new program counter back to the CPU. It tracks logical stack depth and flags overflow and underflow.

## Interface
Parameters:
- `DEPTH`, 16, logical stack capacity in entries; matches the 16-entry stack.

Ports:
- `cpu_clk`  in  1  CPU clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `opcode`  in  16  instruction; captured with `start`.
- `pc`  in  16  address of the current instruction; captured with `start`.
- `stk_we`  out  2  stack command: 2'b00 idle, 2'b01 push, 2'b10 pop.
- `stk_wdata`  out  16  return address pushed to the stack.
- `stk_rdata`  in  16  stack output; registered, valid the cycle after a pop.
- `busy`  out  1  high while not in IDLE.
- `done`  out  1  one-cycle pulse when the request completes.
- `pc_load`  out  1  one-cycle pulse; the CPU loads `new_pc`.
- `new_pc`  out  16  next program counter; valid while `pc_load` is high.
- `fault`  out  1  sticky; set on overflow or underflow and cleared only by `reset`.
- `depth`  out  5  current logical depth, 0..DEPTH.

## Operation
- States: IDLE, PUSH, POP, LOAD, ERR.
- IDLE, with `start` high:
  - Capture `opcode` and `pc`.
  - Decode: `opcode[15:12]==4'h2` is CALL; `opcode==16'h00EE` is RET; anything else is NOP.
- CALL, `depth<DEPTH`: go to PUSH.
- CALL, `depth==DEPTH`: go to ERR.
- RET, `depth>0`: go to POP.
- RET, `depth==0`: go to ERR.
- NOP: go to ERR-free completion. Pulse `done` in the next cycle with no `pc_load` and no stack command, then return to IDLE.
- PUSH (1 cycle):
  - `stk_we=01`; `stk_wdata = pc_cap + 16'd2` (mod 2^16).
  - `new_pc = {4'h0, opcode_cap[11:0]}`; `pc_load=1`; `done=1`.
  - `depth` increments. Next state is IDLE.
- POP (1 cycle): `stk_we=10`; `depth` decrements. Next state is LOAD.
- LOAD (1 cycle): `new_pc = stk_rdata`; `pc_load=1`; `done=1`. Next state is IDLE.
- ERR (1 cycle):
  - Set `fault`; pulse `done`.
  - No stack command, no `pc_load`, `depth` unchanged. Next state is IDLE.
- `start` outside IDLE is ignored and not queued.
- `stk_we` is nonzero for exactly one cycle per accepted CALL/RET and is never 2'b11.

## Timing
- Reset values: state IDLE; `stk_we=0`, `stk_wdata=0`, `busy=0`, `done=0`, `pc_load=0`, `new_pc=0`, `fault=0`, `depth=0`.
- Reset mid-operation: state returns to IDLE at that edge. A push or pop not yet issued is dropped. `depth` restarts at 0, so the stack's own pointer must be reset by the same system reset sequence.
- Latency measured from the `start` edge:
  - CALL: `done`/`pc_load` in cycle +1.
  - RET: pop in cycle +1, `done`/`pc_load` in cycle +2.
  - NOP and ERR: `done` in cycle +1.
- Back-to-back: the next `start` is accepted in the cycle after `done` (IDLE).
- `busy` is high in PUSH, POP, LOAD, ERR, and during the NOP completion cycle.

## Configuration
- `CHIP8_STACK_GUARD_EN` defined:
  - Depth checking as above.
  - Overflow (CALL at DEPTH) and underflow (RET at 0) go to ERR and set `fault`.
- Not defined:
  - No ERR state. `fault` is tied to 0.
  - CALL always pushes; RET always pops.
  - `depth` still counts, wrapping modulo 32, and is informational only.

## Test plan
- CALL: `pc=16'h0200`, `opcode=16'h2345` -> cycle +1: `stk_we=01`, `stk_wdata=16'h0202`, `pc_load=1`, `new_pc=16'h0345`, `depth=1`.
- RET after that CALL, with the stack model returning 16'h0202 -> cycle +1: `stk_we=10`; cycle +2: `pc_load=1`, `new_pc=16'h0202`, `depth=0`.
- 16 nested CALLs, then a 17th -> 17th: no push, `fault=1`, `done` pulse, `depth=16`. Guard on; without the macro, the 17th pushes.
- RET at `depth=0` -> no pop, `fault=1`, `done` at cycle +1; `fault` stays high until `reset`.
- `opcode=16'h6A05` with `start`, plus `start` pulses while busy during a RET -> NOP `done` with no `stk_we`/`pc_load`; the pulses received while busy are ignored.
- `reset` asserted in the POP cycle of a RET -> next cycle: IDLE, all outputs 0, no LOAD cycle.
